// File: rtl/rc4_pkg.sv
// ============================================================================
// Module  : rc4_pkg
// Brief   : Shared types and constants for the RC4 PRGA/decrypt stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_pkg;

  // Main controller states, one per micro-step of the PRGA loop
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_RD_SI,
    ST_CALC_J,
    ST_RD_SJ,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_RD_ENC,
    ST_XOR,
    ST_DEC_REQ,
    ST_DEC_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Phases of a synchronous-RAM read: drive address, let RAM respond, capture
  typedef enum logic [1:0] {
    PH_SET,
    PH_WAIT,
    PH_GET
  } rd_phase_t;

  // Accepted plaintext alphabet: space and lower-case letters
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;

  function automatic logic is_valid_char(input logic [7:0] c);
    return (c == ASCII_SPACE) || ((c >= ASCII_LO) && (c <= ASCII_HI));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc4_prga_decrypt_if.sv
// ============================================================================
// Module  : rc4_prga_decrypt_if
// Brief   : Start/finish handshake to the decrypted-memory interface.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rc4_prga_decrypt_if #(
  parameter int ADR_W = 8
);
  logic             dec_start;
  logic             dec_readWrite;
  logic [ADR_W-1:0] dec_adr;
  logic [7:0]       dec_wdata;
  logic             dec_finish;

  modport master (
    output dec_start,
    output dec_readWrite,
    output dec_adr,
    output dec_wdata,
    input  dec_finish
  );

  modport slave (
    input  dec_start,
    input  dec_readWrite,
    input  dec_adr,
    input  dec_wdata,
    output dec_finish
  );
endinterface

`default_nettype wire

// File: rtl/rc4_read_seq.sv
// ============================================================================
// Module  : rc4_read_seq
// Brief   : SET/WAIT/GET phase sequencer for one synchronous-RAM read. While
//           active it walks the three phases; done marks the GET cycle in
//           which the owner captures read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_read_seq
  import rc4_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  output logic done
);

  rd_phase_t phase;
  rd_phase_t phase_nxt;

  // Phase register; falls back to SET between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase <= PH_SET;
    else          phase <= phase_nxt;
  end

  // Phase advance: SET -> WAIT -> GET -> SET while the owner holds active
  always_comb begin
    phase_nxt = PH_SET;
    if (active) begin
      case (phase)
        PH_SET:  phase_nxt = PH_WAIT;
        PH_WAIT: phase_nxt = PH_GET;
        default: phase_nxt = PH_SET;
      endcase
    end
  end

  assign done = active && (phase == PH_GET);

endmodule

`default_nettype wire

// File: rtl/rc4_prga_decrypt.sv
// ============================================================================
// Module  : rc4_prga_decrypt
// Brief   : RC4 keystream generation and decrypt. For each of MSG_LEN bytes,
//           advances i/j, swaps S[i]/S[j] in S-RAM, XORs S[S[i]+S[j]] with
//           the encrypted ROM byte and writes it to decrypted RAM through
//           the start/finish handshake.
// Options : ASCII_CHECK_EN - abort the run on a non [a-z ] plaintext byte
//           and flag it on key_invalid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADR_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               finish,
  output logic [ADR_W-1:0]   s_adr,
  output logic [7:0]         s_wdata,
  output logic               s_wren,
  input  logic [7:0]         s_rdata,
  output logic [ADR_W-1:0]   rom_adr,
  input  logic [7:0]         rom_rdata,
  rc4_prga_decrypt_if.master dec
`ifdef ASCII_CHECK_EN
  ,
  output logic               key_invalid
`endif
);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] i, j, si, sj, f, enc, pt;
  // One bit wider than a byte index so a 256-byte message still terminates
  logic [8:0] k;
  logic [7:0] plain;
  logic       s_rd_active, s_rd_done;
  logic       rom_rd_active, rom_rd_done;
  logic       last_byte;

  assign plain         = f ^ enc;
  assign s_rd_active   = (state == ST_RD_SI) || (state == ST_RD_SJ) || (state == ST_RD_F);
  assign rom_rd_active = (state == ST_RD_ENC);
  assign last_byte     = (k == 9'(MSG_LEN - 1));

  rc4_read_seq u_s_rd (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (s_rd_active),
    .done    (s_rd_done)
  );

  rc4_read_seq u_rom_rd (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (rom_rd_active),
    .done    (rom_rd_done)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; read states dwell until their sequencer reaches GET
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_INC_I;
      ST_INC_I:    state_nxt = ST_RD_SI;
      ST_RD_SI:    if (s_rd_done) state_nxt = ST_CALC_J;
      ST_CALC_J:   state_nxt = ST_RD_SJ;
      ST_RD_SJ:    if (s_rd_done) state_nxt = ST_WR_I;
      ST_WR_I:     state_nxt = ST_WR_J;
      ST_WR_J:     state_nxt = ST_RD_F;
      ST_RD_F:     if (s_rd_done) state_nxt = ST_RD_ENC;
      ST_RD_ENC:   if (rom_rd_done) state_nxt = ST_XOR;
`ifdef ASCII_CHECK_EN
      ST_XOR:      state_nxt = is_valid_char(plain) ? ST_DEC_REQ : ST_DONE;
`else
      ST_XOR:      state_nxt = ST_DEC_REQ;
`endif
      ST_DEC_REQ:  state_nxt = ST_DEC_WAIT;
      ST_DEC_WAIT: if (dec.dec_finish) state_nxt = ST_NEXT;
      ST_NEXT:     state_nxt = last_byte ? ST_DONE : ST_INC_I;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // PRGA datapath registers, updated in the state that owns each value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i   <= 8'd0;
      j   <= 8'd0;
      k   <= 9'd0;
      si  <= 8'd0;
      sj  <= 8'd0;
      f   <= 8'd0;
      enc <= 8'd0;
      pt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          i <= 8'd0;
          j <= 8'd0;
          k <= 9'd0;
        end
        ST_INC_I:  i <= i + 8'd1;
        ST_RD_SI:  if (s_rd_done) si <= s_rdata;
        ST_CALC_J: j <= j + si;
        ST_RD_SJ:  if (s_rd_done) sj <= s_rdata;
        ST_RD_F:   if (s_rd_done) f <= s_rdata;
        ST_RD_ENC: if (rom_rd_done) enc <= rom_rdata;
        ST_XOR:    pt <= plain;
        ST_NEXT:   if (!last_byte) k <= k + 9'd1;
        default:   ;
      endcase
    end
  end

`ifdef ASCII_CHECK_EN
  // Sticky bad-key flag, cleared when a new run is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          key_invalid <= 1'b0;
    else if ((state == ST_IDLE) && start)  key_invalid <= 1'b0;
    else if ((state == ST_XOR) && !is_valid_char(plain)) key_invalid <= 1'b1;
  end
`endif

  // S-RAM address/data mux; the swap writes S[i]=sj then S[j]=si, which is
  // harmless when i==j because both writes carry the original S[i]
  always_comb begin
    s_adr   = '0;
    s_wdata = 8'd0;
    s_wren  = 1'b0;
    case (state)
      ST_RD_SI: s_adr = ADR_W'(i);
      ST_RD_SJ: s_adr = ADR_W'(j);
      ST_RD_F:  s_adr = ADR_W'(si + sj);
      ST_WR_I: begin
        s_adr   = ADR_W'(i);
        s_wdata = sj;
        s_wren  = 1'b1;
      end
      ST_WR_J: begin
        s_adr   = ADR_W'(j);
        s_wdata = si;
        s_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rom_adr = ADR_W'(k);
  assign finish  = (state == ST_DONE);

  // Decrypted-memory request: pulse start once, hold address/data until finish
  always_comb begin
    dec.dec_start     = (state == ST_DEC_REQ);
    dec.dec_readWrite = (state == ST_DEC_REQ);
    dec.dec_adr       = '0;
    dec.dec_wdata     = 8'd0;
    if ((state == ST_DEC_REQ) || (state == ST_DEC_WAIT)) begin
      dec.dec_adr   = ADR_W'(k);
      dec.dec_wdata = pt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
// ============================================================================
// Module  : tb_rc4_prga_decrypt
// Brief   : Directed bench for rc4_prga_decrypt. Instance 0 has MSG_LEN=2,
//           instance 1 has MSG_LEN=256; each has its own S-RAM, ROM and
//           decrypted-memory responder with programmable finish delay.
// Options : ASCII_CHECK_EN selects the plaintext-check scenarios.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`define CHK(tag, obs, exp) \
  begin \
    nvec++; \
    assert ((obs) === (exp)) else begin \
      nerr++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_rc4_prga_decrypt;

  logic       clk;
  logic       reset_n   [2];
  logic       start     [2];
  logic       finish    [2];
  logic [7:0] s_adr     [2];
  logic [7:0] s_wdata   [2];
  logic       s_wren    [2];
  logic [7:0] s_rdata   [2];
  logic [7:0] rom_adr   [2];
  logic [7:0] rom_rdata [2];
  logic       key_inv   [2];
  logic       init_s    [2];
  logic       dstart    [2];
  logic       drw       [2];
  logic [7:0] dadr      [2];
  logic [7:0] ddat      [2];
  logic       dfin      [2];

  // Responder / monitor state, owned by the stimulus process
  bit         pending   [2];
  int         pend_cnt  [2];
  int         wr_cnt    [2];
  int         fin_cnt   [2];
  logic [8:0] exp_adr   [2];
  logic [7:0] hold_adr  [2];
  logic [7:0] hold_dat  [2];
  logic [7:0] log_dat   [2][256];
  int         dly_tab   [3];

  int         nvec, nerr;
  logic [7:0] ks [256];
  logic [7:0] ms [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ML = (g == 0) ? 2 : 256;
    logic [7:0] smem [256];
    logic [7:0] rom  [256];

    rc4_prga_decrypt_if #(.ADR_W(8)) dif ();

    assign dstart[g]      = dif.dec_start;
    assign drw[g]         = dif.dec_readWrite;
    assign dadr[g]        = dif.dec_adr;
    assign ddat[g]        = dif.dec_wdata;
    assign dif.dec_finish = dfin[g];
`ifndef ASCII_CHECK_EN
    assign key_inv[g]     = 1'b0;
`endif

    rc4_prga_decrypt #(.MSG_LEN(ML), .ADR_W(8)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n[g]),
      .start     (start[g]),
      .finish    (finish[g]),
      .s_adr     (s_adr[g]),
      .s_wdata   (s_wdata[g]),
      .s_wren    (s_wren[g]),
      .s_rdata   (s_rdata[g]),
      .rom_adr   (rom_adr[g]),
      .rom_rdata (rom_rdata[g]),
      .dec       (dif.master)
`ifdef ASCII_CHECK_EN
      ,
      .key_invalid (key_inv[g])
`endif
    );

    // Synchronous S-RAM and ROM models; init_s loads the identity permutation
    always @(posedge clk) begin
      if (init_s[g]) begin
        for (int x = 0; x < 256; x++) smem[x] <= 8'(x);
      end else if (s_wren[g]) begin
        smem[s_adr[g]] <= s_wdata[g];
      end
      s_rdata[g]   <= smem[s_adr[g]];
      rom_rdata[g] <= rom[rom_adr[g]];
    end
  end

  // Per-negedge responder: logs each request, checks the held request, and
  // returns a one-cycle dec_finish after the programmed number of cycles
  task automatic mon(input int g);
    if (!reset_n[g]) begin
      pending[g] = 1'b0;
      dfin[g]    = 1'b0;
      exp_adr[g] = 9'd0;
    end else begin
      if (dfin[g]) dfin[g] = 1'b0;
      if (finish[g]) begin
        fin_cnt[g]++;
        exp_adr[g] = 9'd0;
      end
      if (pending[g]) begin
        `CHK("hold_adr", dadr[g], hold_adr[g])
        `CHK("hold_dat", ddat[g], hold_dat[g])
        `CHK("start_one_cycle", dstart[g], 1'b0)
        if (pend_cnt[g] == 0) begin
          dfin[g]    = 1'b1;
          pending[g] = 1'b0;
        end else begin
          pend_cnt[g]--;
        end
      end else if (dstart[g]) begin
        `CHK("read_write", drw[g], 1'b1)
        `CHK("adr_order", dadr[g], exp_adr[g][7:0])
        hold_adr[g]          = dadr[g];
        hold_dat[g]          = ddat[g];
        log_dat[g][dadr[g]]  = ddat[g];
        pend_cnt[g]          = dly_tab[wr_cnt[g] % 3];
        wr_cnt[g]++;
        exp_adr[g]           = exp_adr[g] + 9'd1;
        pending[g]           = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon(0);
    mon(1);
  endtask

  task automatic load_identity(input int g);
    init_s[g] = 1'b1;
    step();
    init_s[g] = 1'b0;
    step();
  endtask

  task automatic run(input int g, input int budget);
    int f0;
    f0 = fin_cnt[g];
    start[g] = 1'b1;
    step();
    start[g] = 1'b0;
    for (int c = 0; c < budget && fin_cnt[g] == f0; c++) step();
    `CHK("run_completes", (fin_cnt[g] != f0), 1'b1)
    repeat (4) step();
  endtask

  // Reference PRGA over an identity S, recording keystream and final S
  task automatic model(input int n);
    int ii, jj;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    ii = 0;
    jj = 0;
    for (int b = 0; b < n; b++) begin
      ii     = (ii + 1) % 256;
      jj     = (jj + int'(ms[ii])) % 256;
      t      = ms[ii];
      ms[ii] = ms[jj];
      ms[jj] = t;
      ks[b]  = ms[(int'(ms[ii]) + int'(ms[jj])) % 256];
    end
  endtask

  task automatic chk_reset_outputs(input int g);
    `CHK("rst_finish",  finish[g],  1'b0)
    `CHK("rst_s_adr",   s_adr[g],   8'h00)
    `CHK("rst_s_wdata", s_wdata[g], 8'h00)
    `CHK("rst_s_wren",  s_wren[g],  1'b0)
    `CHK("rst_rom_adr", rom_adr[g], 8'h00)
    `CHK("rst_dstart",  dstart[g],  1'b0)
    `CHK("rst_drw",     drw[g],     1'b0)
    `CHK("rst_dadr",    dadr[g],    8'h00)
    `CHK("rst_ddat",    ddat[g],    8'h00)
    `CHK("rst_key_inv", key_inv[g], 1'b0)
  endtask

  initial begin
    int w0, f0, bad;
    nvec = 0;
    nerr = 0;
    dly_tab = '{0, 1, 10};
    for (int g = 0; g < 2; g++) begin
      reset_n[g]  = 1'b0;
      start[g]    = 1'b0;
      init_s[g]   = 1'b0;
      dfin[g]     = 1'b0;
      pending[g]  = 1'b0;
      pend_cnt[g] = 0;
      wr_cnt[g]   = 0;
      fin_cnt[g]  = 0;
      exp_adr[g]  = 9'd0;
    end
    for (int x = 0; x < 256; x++) begin
      g_dut[0].rom[x] = 8'h00;
      g_dut[1].rom[x] = 8'h00;
    end
    repeat (3) step();
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    step();

`ifdef ASCII_CHECK_EN
    // Keystream 0x02 is not [a-z ]: abort after byte 0, no write issued
    load_identity(0);
    w0 = wr_cnt[0];
    f0 = fin_cnt[0];
    run(0, 500);
    `CHK("inv_no_write", wr_cnt[0] - w0, 0)
    `CHK("inv_flag", key_inv[0], 1'b1)
    `CHK("inv_one_finish", fin_cnt[0] - f0, 1)

    // Keystream 0x02,0x05 XOR 0x61,0x60 gives "ce"; flag clears on start
    g_dut[0].rom[0] = 8'h61;
    g_dut[0].rom[1] = 8'h60;
    load_identity(0);
    w0 = wr_cnt[0];
    run(0, 500);
    `CHK("ok_writes", wr_cnt[0] - w0, 2)
    `CHK("ok_byte0", log_dat[0][0], 8'h63)
    `CHK("ok_byte1", log_dat[0][1], 8'h65)
    `CHK("ok_flag", key_inv[0], 1'b0)
`else
    // Two bytes over identity S: keystream 0x02, 0x05; S[2],S[3] swapped
    load_identity(0);
    w0 = wr_cnt[0];
    f0 = fin_cnt[0];
    run(0, 500);
    `CHK("t1_writes", wr_cnt[0] - w0, 2)
    `CHK("t1_finish", fin_cnt[0] - f0, 1)
    `CHK("t1_byte0", log_dat[0][0], 8'h02)
    `CHK("t1_byte1", log_dat[0][1], 8'h05)
    `CHK("t1_s2", g_dut[0].smem[2], 8'h03)
    `CHK("t1_s3", g_dut[0].smem[3], 8'h02)

    // Full 256-byte message: i wraps to 0 on the last byte
    model(256);
    load_identity(1);
    w0 = wr_cnt[1];
    f0 = fin_cnt[1];
    run(1, 9000);
    `CHK("t4_writes", wr_cnt[1] - w0, 256)
    `CHK("t4_finish", fin_cnt[1] - f0, 1)
    for (int b = 0; b < 256; b++) `CHK("t4_byte", log_dat[1][b], ks[b])
    bad = 0;
    for (int x = 0; x < 256; x++) if (g_dut[1].smem[x] !== ms[x]) bad++;
    `CHK("t4_final_s", bad, 0)

    // Reset in DEC_WAIT of byte 5 clears outputs at once; rerun starts at k=0
    dly_tab = '{10, 10, 10};
    load_identity(1);
    w0 = wr_cnt[1];
    f0 = fin_cnt[1];
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int c = 0; c < 1000 && wr_cnt[1] - w0 < 6; c++) step();
    `CHK("t5_reach_byte5", wr_cnt[1] - w0, 6)
    `CHK("t5_adr5", dadr[1], 8'h05)
    step();
    step();
    reset_n[1] = 1'b0;
    #1;
    chk_reset_outputs(1);
    step();
    step();
    reset_n[1] = 1'b1;
    dly_tab = '{0, 1, 10};
    load_identity(1);
    w0 = wr_cnt[1];
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int c = 0; c < 500 && wr_cnt[1] - w0 < 2; c++) step();
    `CHK("t5_restart_writes", wr_cnt[1] - w0, 2)
    `CHK("t5_restart_byte0", log_dat[1][0], 8'h02)
    `CHK("t5_restart_byte1", log_dat[1][1], 8'h05)
    `CHK("t5_no_finish", fin_cnt[1] - f0, 0)
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`undef CHK

`default_nettype wire
